uart_tx_fifo_periph: RTL and testbench
======================================

UART_TX_FIFO_PERIPH -- requirements
Module: uart_tx_fifo_periph

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12_000_000, system clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries; power of two, 2..256.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port bus_valid  input  1  peripheral selected this cycle.
REQ-007 SHALL have port bus_we  input  1  write strobe, qualified by bus_valid.
REQ-008 SHALL have port bus_addr  input  5  byte offset; 0x08 = DATA, 0x10 = STATUS.
REQ-009 SHALL have port bus_wdata  input  32  write data.
REQ-010 SHALL have port bus_rdata  output  32  registered read data.
REQ-011 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-012 SHALL derive CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division); each serial bit is held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL push bus_wdata[7:0] into the FIFO on bus_valid & bus_we & bus_addr==0x08 when count < FIFO_DEPTH; the push is evaluated against count before any same-cycle pop.
REQ-014 SHALL drop a DATA write issued while full, leave the FIFO unchanged, and set sticky overflow.
REQ-015 SHALL clear overflow on bus_valid & bus_we & bus_addr==0x10 & bus_wdata[3]==1; if the clear and an overflow occur in the same cycle, overflow SHALL be set.
REQ-016 SHALL, on a same-cycle push and pop, perform both and keep count unchanged.
REQ-017 SHALL wrap read and write pointers modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: txd=1; if FIFO non-empty, pop the head into the shift register and enter START on the next cycle.
REQ-020 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, then STOP.
REQ-022 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE; a queued byte SHALL start immediately, with no extra idle bit between frames.
REQ-023 SHALL register bus_rdata on bus_valid & !bus_we, valid on the cycle after the request; otherwise bus_rdata holds its value.
REQ-024 STATUS read SHALL return bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow, bits[12:4] count zero-extended, other bits 0.
REQ-025 DATA read SHALL return 0; writes to other offsets SHALL be ignored.

Reset
REQ-026 While resetn=0 at a clock edge: state=IDLE, txd=1, FIFO pointers and count=0, overflow=0, bus_rdata=0, baud and bit counters=0.
REQ-027 Reset mid-frame SHALL abort the frame (txd=1 the next cycle) and discard all queued bytes.
REQ-028 Bus accesses during reset SHALL have no effect.

Configuration
REQ-029 Macro UART_TX_IRQ_EN defined: add output irq (1 bit) and STATUS bit4 irq_en (R/W, reset 0, write via STATUS bus_wdata[4]); count moves to bits[13:5].
REQ-030 With UART_TX_IRQ_EN: irq SHALL be registered, = irq_en & empty & state==IDLE, reset 0.
REQ-031 Without UART_TX_IRQ_EN: no irq port, STATUS bit4 reads 0, count at bits[12:4].

Verification (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, i.e. 10 clks/bit, FIFO_DEPTH=4)
REQ-032 Write 0x55 to DATA -> txd low 10 clks, then 1,0,1,0,1,0,1,0 at 10 clks each, then high 10 clks; busy=1 throughout, STATUS=0x004 after.
REQ-033 Write 0x41, 0x42 back-to-back -> two frames, 200 clks total, stop bit of the first followed directly by the start bit of the second.
REQ-034 Write 6 bytes in consecutive cycles while idle -> first pops at once, 4 queued, 6th dropped; STATUS reads full=1, overflow=1, count=4; STATUS write of 0x8 clears overflow only.
REQ-035 Assert resetn=0 for 1 clk mid-DATA of frame 1 with 2 bytes queued -> txd=1 the next cycle, STATUS=0x004, no further frames.
REQ-036 STATUS read issued -> bus_rdata updates exactly one cycle later; push and pop in the same cycle at count=2 -> count stays 2.
REQ-037 With UART_TX_IRQ_EN: set irq_en, send 1 byte -> irq=0 during the frame, rises 1 clk after return to IDLE; writing irq_en=0 drops irq.

Source files
------------

// File: rtl/uart_tx_fifo_periph.sv
// 8N1 UART transmitter fed by a byte FIFO behind a small register bus (DATA at 0x08, STATUS at 0x10).
// Define UART_TX_IRQ_EN to add the irq output and the STATUS irq_en bit.
module uart_tx_fifo_periph #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
`ifdef UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] ADDR_DATA   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic          txd_next;
  logic          pop, push, full, empty, data_wr, status_wr;
  logic [31:0]   status;
  logic          unused_wdata;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign data_wr   = bus_valid & bus_we & (bus_addr == ADDR_DATA);
  assign status_wr = bus_valid & bus_we & (bus_addr == ADDR_STATUS);
  assign push      = data_wr & ~full;
  assign unused_wdata = ^bus_wdata[31:8];

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= bus_wdata[7:0];
  end

  // Push is judged against the pre-pop count, so a full FIFO drops the write even if a pop happens.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (data_wr && full)                   overflow <= 1'b1;
      else if (status_wr && bus_wdata[3])    overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      txd      <= txd_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        // A queued byte goes straight into its start bit so frames abut with no idle gap.
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    txd_next = (state_next == START) ? 1'b0 :
               (state_next == DATA)  ? shift_next[0] : 1'b1;
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (status_wr) irq_en <= bus_wdata[4];
      irq <= irq_en & empty & (state == IDLE);
    end
  end
`endif

  always_comb begin
    status    = '0;
    status[0] = (state != IDLE);
    status[1] = full;
    status[2] = empty;
    status[3] = overflow;
`ifdef UART_TX_IRQ_EN
    status[4]    = irq_en;
    status[13:5] = 9'(count);
`else
    status[12:4] = 9'(count);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_rdata <= '0;
    end else if (bus_valid && !bus_we) begin
      bus_rdata <= (bus_addr == ADDR_STATUS) ? status : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_periph.sv
// Scoreboard bench for uart_tx_fifo_periph: queued bytes are checked against decoded serial frames
// sample-by-sample, plus STATUS/bus timing checks at 10 clks/bit with a 4-entry FIFO.
module tb_uart_tx_fifo_periph;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD_RATE   = 100_000;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = 10;
  localparam int FRAME       = 10 * CPB;
  localparam logic [4:0] ADDR_DATA   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        txd;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int start_log[$];
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;

  uart_tx_fifo_periph #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus_valid(bus_valid),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
`ifdef UART_TX_IRQ_EN
    .irq      (irq),
`endif
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                              input bit ovf, input int cnt);
    logic [31:0] w;
    w = '0;
    w[0] = busy;
    w[1] = full;
    w[2] = empty;
    w[3] = ovf;
`ifdef UART_TX_IRQ_EN
    w[13:5] = 9'(cnt);
`else
    w[12:4] = 9'(cnt);
`endif
    return w;
  endfunction

  // Frame monitor: once txd goes low, every one of the next 100 negedge samples must match the
  // start/data/stop pattern of the byte at the head of the scoreboard.
  logic [9:0] mon_pat;
  logic [7:0] mon_byte;
  bit         mon_expected;
  int         mon_bad, mon_first;
  logic       mon_got;
  always begin
    @(negedge clk);
    if (mon_en && txd === 1'b0) begin
      mon_busy = 1'b1;
      start_log.push_back(cyc);
      if (sb.size() > 0) begin
        mon_expected = 1'b1;
        mon_byte = sb.pop_front();
      end else begin
        mon_expected = 1'b0;
        mon_byte = 8'hFF;
      end
      mon_pat = {1'b1, mon_byte, 1'b0};
      mon_bad = 0;
      mon_first = -1;
      mon_got = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if (!mon_en) break;
        if (txd !== mon_pat[i / CPB]) begin
          mon_bad++;
          if (mon_first < 0) begin
            mon_first = i;
            mon_got = txd;
          end
        end
      end
      if (mon_en) begin
        checks++;
        if (!mon_expected) begin
          errors++;
          $display("[TB] FAIL frame_unexpected: frame started at cycle %0d with nothing queued, required no frame", start_log[$]);
        end else if (mon_bad != 0) begin
          errors++;
          $display("[TB] FAIL frame_%02h: %0d wrong txd samples, first at clk %0d of frame: got %b, required %b",
                   mon_byte, mon_bad, mon_first, mon_got, mon_pat[mon_first / CPB]);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = a;
    @(negedge clk);
    bus_valid = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_idle(input int limit, input string what);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || mon_busy) begin
      errors++;
      $display("[TB] FAIL %s_timeout: %0d frames pending after %0d clks, required 0", what, sb.size(), limit);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    bus_write(ADDR_DATA, 32'h77);
    bus_write(ADDR_STATUS, 32'h08);
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_txd: txd=%b, required 1", txd);
    end
    checks++;
    if (bus_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: bus_rdata=%h, required 00000000", bus_rdata);
    end
    resetn = 1'b1;
    mon_en = 1'b1;
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_status: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] d;
    int n0, wcyc;
    n0 = start_log.size();
    sb.push_back(8'h55);
    bus_write(ADDR_DATA, 32'h0000_0155);
    wcyc = cyc;
    for (int k = 0; k < 3; k++) begin
      repeat (25) @(negedge clk);
      bus_read(ADDR_STATUS, d);
      checks++;
      if (d !== status_word(1, 0, 1, 0, 0)) begin
        errors++;
        $display("[TB] FAIL single_busy%0d: STATUS=%h, required %h", k, d, status_word(1, 0, 1, 0, 0));
      end
    end
    wait_idle(300, "single");
    checks++;
    if (start_log.size() <= n0 || start_log[n0] - wcyc != 1) begin
      errors++;
      $display("[TB] FAIL single_latency: start bit %0d clks after write, required 1",
               (start_log.size() > n0) ? start_log[n0] - wcyc : -1);
    end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL single_status_after: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = start_log.size();
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    bus_write(ADDR_DATA, 32'h41);
    bus_write(ADDR_DATA, 32'h42);
    wait_idle(400, "back_to_back");
    checks++;
    if (start_log.size() - n0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_frames: %0d frames, required 2", start_log.size() - n0);
    end else begin
      checks++;
      if (start_log[n0 + 1] - start_log[n0] != FRAME) begin
        errors++;
        $display("[TB] FAIL b2b_gap: second start %0d clks after first, required %0d",
                 start_log[n0 + 1] - start_log[n0], FRAME);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) sb.push_back(8'hA1 + 8'(i));
    for (int i = 0; i < 6; i++) bus_write(ADDR_DATA, 32'hA1 + 32'(i));
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(1, 1, 0, 1, 4)) begin
      errors++;
      $display("[TB] FAIL overflow_status: STATUS=%h, required %h", d, status_word(1, 1, 0, 1, 4));
    end
    bus_write(ADDR_STATUS, 32'h8);
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(1, 1, 0, 0, 4)) begin
      errors++;
      $display("[TB] FAIL overflow_clear: STATUS=%h, required %h", d, status_word(1, 1, 0, 0, 4));
    end
    wait_idle(800, "overflow");
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL overflow_drained: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [31:0] d;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    sb.push_back(8'h44);
    bus_write(ADDR_DATA, 32'h11);
    bus_write(ADDR_DATA, 32'h22);
    bus_write(ADDR_DATA, 32'h33);
    // Land the next write on the edge that ends frame 1 and pops 0x22 (count is 2 there).
    repeat (98) @(negedge clk);
    bus_write(ADDR_DATA, 32'h44);
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(1, 0, 0, 0, 2)) begin
      errors++;
      $display("[TB] FAIL push_pop_count: STATUS=%h, required %h", d, status_word(1, 0, 0, 0, 2));
    end
    wait_idle(600, "push_pop");
  endtask

  task automatic test_read_latency();
    logic [31:0] d;
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL read_status: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
    bus_read(ADDR_DATA, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_data_reg: DATA read=%h, required 00000000", d);
    end
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = ADDR_STATUS;
    #1;
    checks++;
    if (bus_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_early: bus_rdata=%h before the edge, required 00000000", bus_rdata);
    end
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    checks++;
    if (bus_rdata !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL read_one_cycle: bus_rdata=%h, required %h", bus_rdata, status_word(0, 0, 1, 0, 0));
    end
    bus_addr = ADDR_DATA;
    repeat (5) @(negedge clk);
    checks++;
    if (bus_rdata !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL read_hold: bus_rdata=%h, required %h", bus_rdata, status_word(0, 0, 1, 0, 0));
    end
  endtask

  task automatic test_offsets();
    logic [31:0] d;
    int n0;
    n0 = start_log.size();
    bus_write(5'h0C, 32'hAB);
    bus_write(5'h00, 32'hCD);
    bus_write(5'h14, 32'h3F);
    bus_write(5'h09, 32'h12);
    repeat (20) @(negedge clk);
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL offsets_status: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
    checks++;
    if (start_log.size() != n0) begin
      errors++;
      $display("[TB] FAIL offsets_frames: %0d frames, required 0", start_log.size() - n0);
    end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    int n;
    bus_write(ADDR_STATUS, 32'h10);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_enable: irq=%b, required 1", irq);
    end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== (status_word(0, 0, 1, 0, 0) | 32'h10)) begin
      errors++;
      $display("[TB] FAIL irq_status: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0) | 32'h10);
    end
    sb.push_back(8'h5A);
    bus_write(ADDR_DATA, 32'h5A);
    repeat (20) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_in_frame: irq=%b, required 0", irq);
    end
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_early: irq=%b on the return-to-idle cycle, required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_rise: irq=%b one clk after idle, required 1", irq);
    end
    bus_write(ADDR_STATUS, 32'h0);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_disable: irq=%b, required 0", irq);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int lows;
    sb.push_back(8'h00);
    sb.push_back(8'hC3);
    sb.push_back(8'h3C);
    bus_write(ADDR_DATA, 32'h00);
    bus_write(ADDR_DATA, 32'hC3);
    bus_write(ADDR_DATA, 32'h3C);
    repeat (40) @(negedge clk);
    mon_en    = 1'b0;
    resetn    = 1'b0;
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = ADDR_DATA;
    bus_wdata = 32'h99;
    @(negedge clk);
    resetn    = 1'b1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_txd: txd=%b after reset, required 1", txd);
    end
    sb.delete();
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== status_word(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL midreset_status: STATUS=%h, required %h", d, status_word(0, 0, 1, 0, 0));
    end
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: txd low for %0d clks after reset, required 0", lows);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    $display("[TB] uart_tx_fifo_periph bench start");
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop_same_cycle();
    test_read_latency();
    test_offsets();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
